mult_wb_buffer: RTL and testbench
=================================

// Module: mult_wb_buffer
// PURPOSE
//  Consumer side of the mult functional unit's output interface. Captures completed
//  multiplies (done/result/output_robn/output_dest_prn) into a small in-order FIFO.
//  Back-pressures the mult pipeline through avail.
//  Presents the oldest entry to the CDB arbiter with a req/grant handshake.
//  Sits between mult and the CDB.
// PARAMETERS
//  DEPTH  4  FIFO entries (power of two, >=2); bounds results held awaiting CDB grant
// PORTS
//  Clocking: single clock `clock`; reset is synchronous, active-high `reset`.
//  clock            in   1              system clock, all state on posedge
//  reset            in   1              synchronous, active-high reset
//  squash           in   1              mispredict flush; clears buffer
//  done             in   1              mult has a valid result this cycle
//  result           in   DATA (32)      mult result
//  output_robn      in   ROBN           ROB tag of result
//  output_dest_prn  in   PRN            destination physical register
//  avail            out  1              mult may advance its pipeline this cycle
//  cdb_req          out  1              head entry valid, requesting CDB
//  cdb_grant        in   1              arbiter grants CDB to this unit this cycle
//  cdb_value        out  DATA (32)      head entry result
//  cdb_robn         out  ROBN           head entry ROB tag
//  cdb_prn          out  PRN            head entry dest PRN
//  count            out  $clog2(DEPTH)+1  current occupancy
// BEHAVIOUR
//  - Reset values: count=0, cdb_req=0, cdb_value/cdb_robn/cdb_prn=0, avail=1.
//    Head/tail pointers are 0 and all entries are invalid.
//  - pop = cdb_req & cdb_grant.
//  - avail = (count != DEPTH) | pop.
//    This is a combinational path from cdb_grant; the result is never a loop because
//    mult registers avail internally.
//  - push = done & avail.
//    done & !avail is a protocol violation: an assertion fires and the input is dropped.
//  - Push writes the entry at the tail and the tail increments mod DEPTH.
//    Pop advances the head mod DEPTH.
//  - Pointer wrap uses $clog2(DEPTH) bits; count disambiguates full from empty.
//  - Push+pop in the same cycle: count is unchanged. This is legal when full
//    (avail=1 via pop) and when count=1.
//  - Latency: an entry pushed at edge N drives cdb_req/cdb_* from cycle N+1.
//    There is no same-cycle bypass from done to cdb_*.
//  - cdb_req = (count != 0).
//    cdb_value/cdb_robn/cdb_prn = head entry when cdb_req=1, else 0.
//  - Order: results leave in the exact order they were pushed (mult completion order).
//  - Ungranted request: cdb_req stays high and the head is held stable until cdb_grant.
//  - squash (synchronous, priority below reset): next cycle count=0, cdb_req=0,
//    pointers=0.
//    A push or pop in the squash cycle is discarded. avail stays as computed that cycle.
//  - reset mid-operation: same effect as squash; all outputs return to reset values
//    next cycle.
//  - No state beyond the FIFO. count is registered and never exceeds DEPTH.
// TESTING
//  1. Reset:
//     hold reset 2 cycles -> count=0, cdb_req=0, avail=1, cdb_*=0.
//  2. Single result:
//     done=1, result=25, robn=1, prn=1 for one cycle
//     -> next cycle cdb_req=1, cdb_value=25, cdb_robn=1.
//     Grant -> following cycle cdb_req=0, count=0.
//  3. Fill/back-pressure, DEPTH=4, cdb_grant=0:
//     push robn 1..4 on consecutive cycles -> count=4, avail=0.
//     A done with robn=5 while avail=0 -> assertion, count stays 4.
//  4. Full with simultaneous push/pop:
//     count=4, grant=1, done=1 robn=5 -> avail=1, count stays 4.
//     Drains in order robn 2,3,4,5 with grant held high.
//  5. Wrap-around:
//     push/pop 10 results (robn 1..10) with grant on alternate cycles
//     -> CDB tags appear strictly 1..10 with no loss.
//  6. Squash:
//     count=3 with done=1 in the squash cycle -> next cycle count=0, cdb_req=0.
//     The next push (robn=7) appears alone on the CDB.

Source files
------------

// File: rtl/mult_wb_buffer.sv
// mult_wb_buffer: in-order result FIFO between the mult unit and the CDB arbiter.
// Completed multiplies are captured when the unit is not full. The oldest entry
// is presented on cdb_* with a req/grant handshake. avail back-pressures mult.
module mult_wb_buffer #(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ROBN_W         = 5,
    parameter int unsigned PRN_W          = 6,
    parameter bit          PROTOCOL_CHECK = 1'b1
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       squash,
    input  logic                       done,
    input  logic [DATA_W-1:0]          result,
    input  logic [ROBN_W-1:0]          output_robn,
    input  logic [PRN_W-1:0]           output_dest_prn,
    output logic                       avail,
    output logic                       cdb_req,
    input  logic                       cdb_grant,
    output logic [DATA_W-1:0]          cdb_value,
    output logic [ROBN_W-1:0]          cdb_robn,
    output logic [PRN_W-1:0]           cdb_prn,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] value_mem [DEPTH];
    logic [ROBN_W-1:0] robn_mem  [DEPTH];
    logic [PRN_W-1:0]  prn_mem   [DEPTH];

    logic [PTR_W-1:0]  head;
    logic [PTR_W-1:0]  tail;
    logic [CNT_W-1:0]  occupancy;
    logic              push;
    logic              pop;

    // Handshake decode; avail may rise on a full buffer when the head is leaving.
    always_comb begin
        cdb_req = (occupancy != '0);
        pop     = cdb_req & cdb_grant;
        avail   = (occupancy != CNT_W'(DEPTH)) | pop;
        push    = done & avail;
        count   = occupancy;
    end

    // Head entry is driven only while a request is outstanding, zero otherwise.
    always_comb begin
        cdb_value = '0;
        cdb_robn  = '0;
        cdb_prn   = '0;
        if (cdb_req) begin
            cdb_value = value_mem[head];
            cdb_robn  = robn_mem[head];
            cdb_prn   = prn_mem[head];
        end
    end

    // Pointer and occupancy update; reset and squash both empty the buffer.
    always_ff @(posedge clock) begin
        if (reset || squash) begin
            head      <= '0;
            tail      <= '0;
            occupancy <= '0;
        end else begin
            if (push) begin
                tail <= tail + 1'b1;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            if (push && !pop) begin
                occupancy <= occupancy + 1'b1;
            end else if (pop && !push) begin
                occupancy <= occupancy - 1'b1;
            end
        end
    end

    // Entry storage; validity is implied by occupancy so the data needs no reset.
    always_ff @(posedge clock) begin
        if (push && !reset && !squash) begin
            value_mem[tail] <= result;
            robn_mem[tail]  <= output_robn;
            prn_mem[tail]   <= output_dest_prn;
        end
    end

    // mult must never present a result while avail is low; such a result is dropped.
    generate
        if (PROTOCOL_CHECK) begin : g_protocol_check
            a_no_done_without_avail : assert property (
                @(posedge clock) disable iff (reset) !(done && !avail)
            ) else $error("mult_wb_buffer: done asserted while avail low, result dropped");
        end
    endgenerate

endmodule

// File: tb/tb_mult_wb_buffer.sv
// tb_mult_wb_buffer: table vectors plus hand sequences, checked against a queue
// scoreboard that models the FIFO occupancy, handshake and head entry.
module tb_mult_wb_buffer;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [31:0] v;
        logic [4:0]  r;
        logic [5:0]  p;
    } ent_t;

    typedef struct {
        logic        d;
        logic        g;
        logic [31:0] v;
        logic [4:0]  r;
        logic [5:0]  p;
        int          exp_count;
        logic        exp_req;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        squash = 1'b0;
    logic        done = 1'b0;
    logic [31:0] result = '0;
    logic [4:0]  output_robn = '0;
    logic [5:0]  output_dest_prn = '0;
    logic        avail;
    logic        cdb_req;
    logic        cdb_grant = 1'b0;
    logic [31:0] cdb_value;
    logic [4:0]  cdb_robn;
    logic [5:0]  cdb_prn;
    logic [2:0]  count;

    int   checks = 0;
    int   errors = 0;
    ent_t sb[$];
    int   pop_log[$];

    mult_wb_buffer #(
        .DEPTH(DEPTH),
        .DATA_W(32),
        .ROBN_W(5),
        .PRN_W(6),
        .PROTOCOL_CHECK(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .squash(squash),
        .done(done),
        .result(result),
        .output_robn(output_robn),
        .output_dest_prn(output_dest_prn),
        .avail(avail),
        .cdb_req(cdb_req),
        .cdb_grant(cdb_grant),
        .cdb_value(cdb_value),
        .cdb_robn(cdb_robn),
        .cdb_prn(cdb_prn),
        .count(count)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One clock cycle: drive inputs, check mid-cycle against the model, clock, update model.
    task automatic cycle(input logic rs, input logic s, input logic d, input logic g,
                         input logic [31:0] v, input logic [4:0] r, input logic [5:0] p);
        ent_t e;
        logic exp_pop;
        logic exp_avail;
        logic exp_push;
        reset = rs; squash = s; done = d; cdb_grant = g;
        result = v; output_robn = r; output_dest_prn = p;
        #4;
        exp_pop   = g && (sb.size() != 0);
        exp_avail = (sb.size() != DEPTH) || exp_pop;
        exp_push  = d && exp_avail;
        check("count", 64'(count), 64'(sb.size()));
        check("cdb_req", 64'(cdb_req), 64'(sb.size() != 0));
        check("avail", 64'(avail), 64'(exp_avail));
        if (sb.size() != 0) begin
            e = sb[0];
            check("cdb_value", 64'(cdb_value), 64'(e.v));
            check("cdb_robn", 64'(cdb_robn), 64'(e.r));
            check("cdb_prn", 64'(cdb_prn), 64'(e.p));
        end else begin
            check("cdb_idle", {cdb_value, cdb_robn, cdb_prn}, 64'd0);
        end
        @(posedge clock);
        #1;
        if (rs || s) begin
            sb.delete();
        end else begin
            if (exp_pop) begin
                e = sb.pop_front();
                pop_log.push_back(int'(e.r));
            end
            if (exp_push) begin
                e.v = v; e.r = r; e.p = p;
                sb.push_back(e);
            end
        end
        reset = 1'b0; squash = 1'b0; done = 1'b0; cdb_grant = 1'b0;
    endtask

    task automatic check_pop_order(input string name, input int first, input int n);
        check({name, "_len"}, 64'(pop_log.size()), 64'(n));
        for (int i = 0; i < n && i < pop_log.size(); i++) begin
            check(name, 64'(pop_log[i]), 64'(first + i));
        end
    endtask

    initial begin
        vec_t vecs[7];
        int   next;
        logic g;
        logic d;
        logic pa;
        bit   finished;

        vecs[0] = '{1'b1, 1'b0, 32'd25,         5'd1,  6'd1,  1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 32'd0,          5'd0,  6'd0,  0, 1'b0};
        vecs[2] = '{1'b1, 1'b0, 32'hFFFF_FFFF,  5'd31, 6'd63, 1, 1'b1};
        vecs[3] = '{1'b1, 1'b1, 32'h0000_1234,  5'd2,  6'd3,  1, 1'b1};
        vecs[4] = '{1'b0, 1'b0, 32'd0,          5'd0,  6'd0,  1, 1'b1};
        vecs[5] = '{1'b0, 1'b1, 32'd0,          5'd0,  6'd0,  0, 1'b0};
        vecs[6] = '{1'b0, 1'b1, 32'd0,          5'd0,  6'd0,  0, 1'b0};

        // Reset held two cycles.
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check("rst_count", 64'(count), 64'd0);
        check("rst_req", 64'(cdb_req), 64'd0);
        check("rst_avail", 64'(avail), 64'd1);
        check("rst_cdb", {cdb_value, cdb_robn, cdb_prn}, 64'd0);
        reset = 1'b0;

        // Single result and basic handshake patterns.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, 1'b0, vecs[i].d, vecs[i].g, vecs[i].v, vecs[i].r, vecs[i].p);
            check("vec_count", 64'(count), 64'(vecs[i].exp_count));
            check("vec_req", 64'(cdb_req), 64'(vecs[i].exp_req));
        end

        // Fill with no grant, then a dropped result while full.
        pop_log.delete();
        for (int i = 1; i <= 4; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'(i * 100), 5'(i), 6'(i + 10));
        check("full_count", 64'(count), 64'd4);
        check("full_avail", 64'(avail), 64'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd500, 5'd5, 6'd15);
        check("drop_count", 64'(count), 64'd4);

        // Full with simultaneous push and pop, then drain in order.
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 32'd555, 5'd5, 6'd15);
        check("pp_count", 64'(count), 64'd4);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 6'd0);
        check("drain_count", 64'(count), 64'd0);
        check_pop_order("drain_order", 1, 5);

        // Wrap-around: ten results, grant on alternate cycles.
        pop_log.delete();
        next = 1;
        finished = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (next > 10 && sb.size() == 0) begin
                finished = 1'b1;
                break;
            end
            g  = c[0];
            pa = (sb.size() != DEPTH) || (g && sb.size() != 0);
            d  = (next <= 10) && pa;
            cycle(1'b0, 1'b0, d, g, 32'(next * 7 + 3), 5'(next), 6'(next + 20));
            if (d) next++;
        end
        check("wrap_finished", 64'(finished), 64'd1);
        check_pop_order("wrap_order", 1, 10);

        // Squash with a push and grant in the same cycle.
        for (int i = 1; i <= 3; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'(i), 5'(i), 6'(i));
        check("pre_sq_count", 64'(count), 64'd3);
        cycle(1'b0, 1'b1, 1'b1, 1'b1, 32'd9, 5'd9, 6'd9);
        check("sq_count", 64'(count), 64'd0);
        check("sq_req", 64'(cdb_req), 64'd0);
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'd77, 5'd7, 6'd17);
        check("post_sq_count", 64'(count), 64'd1);
        check("post_sq_robn", 64'(cdb_robn), 64'd7);
        check("post_sq_value", 64'(cdb_value), 64'd77);
        cycle(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 5'd0, 6'd0);

        // Reset mid-operation with a pending push.
        for (int i = 1; i <= 2; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0, 32'(i + 40), 5'(i), 6'(i));
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 32'd99, 5'd3, 6'd3);
        check("mrst_count", 64'(count), 64'd0);
        check("mrst_req", 64'(cdb_req), 64'd0);
        check("mrst_avail", 64'(avail), 64'd1);
        check("mrst_cdb", {cdb_value, cdb_robn, cdb_prn}, 64'd0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 5'd0, 6'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
